glycemic_alarm_monitor: RTL and testbench

Sequential supervisor directly downstream of the glycemic index calculator in the health-care datapath. It samples the 4-bit glycemic index on a valid strobe and keeps a 4-sample running average. A debounced state machine classifies the patient as normal, hyperglycemic or hypoglycemic. It raises an alarm and issues a one-shot insulin-request handshake toward the dosing controller.

---
 rtl/glycemic_alarm_monitor_if.sv | 24 ++
 rtl/glycemic_alarm_monitor.sv | 154 +++++++++++++++
 tb/tb_glycemic_alarm_monitor.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/glycemic_alarm_monitor_if.sv
// Handshake/sample bus between the glycemic index calculator, the alarm
// monitor and the insulin dosing controller.
interface glycemic_alarm_monitor_if;
    logic       sampleValid;
    logic [3:0] glycemicIndex;
    logic       insulinAck;
    logic [3:0] avgIndex;
    logic [1:0] state;
    logic       alarm;
    logic       insulinReq;
    logic [7:0] sampleCount;

    // Upstream side: supplies samples and the dosing acknowledge.
    modport master (
        output sampleValid, glycemicIndex, insulinAck,
        input  avgIndex, state, alarm, insulinReq, sampleCount
    );

    // Monitor side.
    modport slave (
        input  sampleValid, glycemicIndex, insulinAck,
        output avgIndex, state, alarm, insulinReq, sampleCount
    );
endinterface

// File: rtl/glycemic_alarm_monitor.sv
// Glycemic alarm monitor: 4-sample running average, debounced
// NORMAL/HYPER/HYPO classifier and a one-shot insulin request handshake.
module glycemic_alarm_monitor #(
    parameter int unsigned HIGH_TH = 6,
    parameter int unsigned LOW_TH  = 2,
    parameter int unsigned CONFIRM = 3   // 1..7, must fit the 3-bit qualify counter
) (
    input logic                     clk,
    input logic                     rst,
    glycemic_alarm_monitor_if.slave bus
);

    localparam logic [3:0] HIGH_LVL    = 4'(HIGH_TH);
    localparam logic [3:0] LOW_LVL     = 4'(LOW_TH);
    localparam logic [3:0] CONFIRM_CNT = 4'(CONFIRM);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        HYPER  = 2'b01,
        HYPO   = 2'b10
    } monStateT;

    monStateT   stateQ;
    monStateT   nextState;
    logic [2:0] qCnt;
    logic [2:0] nextQCnt;
    logic       dirHigh;       // direction of the current NORMAL-state streak
    logic       nextDirHigh;
    logic [3:0] runLen;        // streak length including the current sample
    logic [3:0] sample;
    logic       isHigh;
    logic       isLow;
    logic [3:0] hist [4];
    logic [5:0] histSum;
    logic [7:0] sampleCountQ;
    logic       insulinReqQ;

    // Indices above 8 are saturated before they reach any of the logic.
    assign sample = (bus.glycemicIndex > 4'd8) ? 4'd8 : bus.glycemicIndex;
    assign isHigh = (sample >= HIGH_LVL);
    assign isLow  = (sample <= LOW_LVL);

    // State register with the qualify counter and streak direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ  <= NORMAL;
            qCnt    <= '0;
            dirHigh <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would create order-dependent races.
            stateQ  <= nextState;
            qCnt    <= nextQCnt;
            dirHigh <= nextDirHigh;
        end
    end

    // Next-state logic: debounce qualifying samples until CONFIRM is reached.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        nextState   = stateQ;
        nextQCnt    = qCnt;
        nextDirHigh = dirHigh;
        runLen      = {1'b0, qCnt} + 4'd1;
        if (bus.sampleValid) begin
            unique case (stateQ)
                NORMAL: begin
                    if (isHigh || isLow) begin
                        // A change of direction restarts the streak at one.
                        if (dirHigh != isHigh) begin
                            runLen = 4'd1;
                        end
                        nextDirHigh = isHigh;
                        if (runLen >= CONFIRM_CNT) begin
                            nextState = isHigh ? HYPER : HYPO;
                            nextQCnt  = '0;
                        end else begin
                            nextQCnt = runLen[2:0];
                        end
                    end else begin
                        nextQCnt = '0;
                    end
                end
                HYPER, HYPO: begin
                    if ((stateQ == HYPER) ? (sample < HIGH_LVL) : (sample > LOW_LVL)) begin
                        if (runLen >= CONFIRM_CNT) begin
                            nextState = NORMAL;
                            nextQCnt  = '0;
                        end else begin
                            nextQCnt = runLen[2:0];
                        end
                    end else begin
                        nextQCnt = '0;
                    end
                end
                default: begin
                    nextState = NORMAL;
                    nextQCnt  = '0;
                end
            endcase
        end
    end

    // Sample history shift register feeding the running average.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the history is a small register file that must read as zero
            // before four samples arrive, so it is reset like any other state.
            for (int i = 0; i < 4; i++) begin
                hist[i] <= '0;
            end
        end else if (bus.sampleValid) begin
            hist[0] <= sample;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
        end
    end

    // Accepted-sample counter, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sampleCountQ <= '0;
        end else if (bus.sampleValid && (sampleCountQ != 8'hFF)) begin
            sampleCountQ <= sampleCountQ + 8'd1;
        end
    end

    // Insulin request: raised on HYPER entry, dropped on ack or HYPER exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            insulinReqQ <= 1'b0;
        end else if ((stateQ != HYPER) && (nextState == HYPER)) begin
            insulinReqQ <= 1'b1;
        end else if ((stateQ == HYPER) && (nextState != HYPER)) begin
            insulinReqQ <= 1'b0;
        end else if (bus.insulinAck) begin
            insulinReqQ <= 1'b0;
        end
    end

    // Output logic: every output is a function of registers only.
    always_comb begin
        histSum         = {2'b00, hist[0]} + {2'b00, hist[1]}
                        + {2'b00, hist[2]} + {2'b00, hist[3]};
        bus.avgIndex    = 4'(histSum >> 2);
        bus.state       = stateQ;
        bus.alarm       = (stateQ != NORMAL);
        bus.insulinReq  = insulinReqQ;
        bus.sampleCount = sampleCountQ;
    end

endmodule

// File: tb/tb_glycemic_alarm_monitor.sv
// Self-checking bench for glycemic_alarm_monitor: directed scenarios plus
// randomized traffic compared against a queue-based behavioural model.
module tb_glycemic_alarm_monitor;

    localparam int HIGH_TH = 6;
    localparam int LOW_TH  = 2;
    localparam int CONFIRM = 3;

    logic clk = 1'b0;
    logic rst;

    glycemic_alarm_monitor_if bus ();

    glycemic_alarm_monitor #(
        .HIGH_TH (HIGH_TH),
        .LOW_TH  (LOW_TH),
        .CONFIRM (CONFIRM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, kept in spec terms.
    int hist[$];      // newest first, always four entries
    int mCount;
    int mState;       // 0 NORMAL, 1 HYPER, 2 HYPO
    int streak[$];    // targets of the current run of consecutive qualifying samples
    bit mReq;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        hist   = '{0, 0, 0, 0};
        mCount = 0;
        mState = 0;
        streak.delete();
        mReq   = 1'b0;
    endtask

    function automatic int modelAvg();
        int s = 0;
        foreach (hist[i]) s += hist[i];
        return s / 4;
    endfunction

    task automatic modelStep(input bit v, input int raw, input bit a);
        int g;
        int prev;
        int target;
        prev = mState;
        if (v) begin
            g = (raw > 8) ? 8 : raw;
            hist.push_front(g);
            void'(hist.pop_back());
            if (mCount < 255) mCount++;
            target = -1;
            if (mState == 0) begin
                if (g >= HIGH_TH) target = 1;
                else if (g <= LOW_TH) target = 2;
            end else if (mState == 1) begin
                if (g < HIGH_TH) target = 0;
            end else begin
                if (g > LOW_TH) target = 0;
            end
            if (target < 0) begin
                streak.delete();
            end else begin
                if (streak.size() > 0 && streak[$] != target) streak.delete();
                streak.push_back(target);
                if (streak.size() >= CONFIRM) begin
                    mState = target;
                    streak.delete();
                end
            end
        end
        if (prev != 1 && mState == 1)      mReq = 1'b1;
        else if (prev == 1 && mState != 1) mReq = 1'b0;
        else if (a)                        mReq = 1'b0;
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".avgIndex"},    int'(bus.avgIndex),    modelAvg());
        check({tag, ".state"},       int'(bus.state),       mState);
        check({tag, ".alarm"},       int'(bus.alarm),       (mState != 0) ? 1 : 0);
        check({tag, ".insulinReq"},  int'(bus.insulinReq),  int'(mReq));
        check({tag, ".sampleCount"}, int'(bus.sampleCount), mCount);
    endtask

    // Called just after a falling edge; leaves the bench on the next falling edge.
    task automatic step(input bit v, input int g, input bit a, input string tag);
        bus.sampleValid   = v;
        bus.glycemicIndex = 4'(g);
        bus.insulinAck    = a;
        @(posedge clk);
        modelStep(v, g, a);
        @(negedge clk);
        checkAll(tag);
    endtask

    task automatic feed(input int g, input string tag);
        step(1'b1, g, 1'b0, tag);
    endtask

    task automatic syncReset();
        bus.sampleValid = 1'b0;
        bus.insulinAck  = 1'b0;
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        bus.sampleValid   = 1'b0;
        bus.glycemicIndex = '0;
        bus.insulinAck    = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll("reset");
        rst = 1'b0;

        // Average ramp with zero-filled history.
        for (int i = 0; i < 4; i++) feed(4, "ramp");
        check("ramp.avgFinal", int'(bus.avgIndex), 4);

        // Enter HYPER, acknowledge, no second request.
        for (int i = 0; i < 3; i++) feed(7, "hyperIn");
        check("hyperIn.stateConst", int'(bus.state), 1);
        check("hyperIn.reqConst", int'(bus.insulinReq), 1);
        step(1'b0, 0, 1'b1, "ack");
        check("ack.reqDropped", int'(bus.insulinReq), 0);
        feed(7, "hyperHold");
        check("hyperHold.noNewReq", int'(bus.insulinReq), 0);

        // Back to NORMAL, then a broken streak that must not trigger.
        for (int i = 0; i < 3; i++) feed(5, "hyperOut1");
        feed(7, "broken"); feed(7, "broken"); feed(4, "broken");
        feed(7, "broken"); feed(7, "broken");
        check("broken.stateConst", int'(bus.state), 0);

        // Third high completes the new streak; then leave HYPER without ack.
        feed(7, "hyperIn2");
        check("hyperIn2.reqConst", int'(bus.insulinReq), 1);
        for (int i = 0; i < 3; i++) feed(5, "hyperOut2");
        check("hyperOut2.reqCleared", int'(bus.insulinReq), 0);
        check("hyperOut2.alarmCleared", int'(bus.alarm), 0);

        // HYPO entry and exit.
        feed(1, "hypoIn"); feed(0, "hypoIn"); feed(2, "hypoIn");
        check("hypoIn.stateConst", int'(bus.state), 2);
        check("hypoIn.noReq", int'(bus.insulinReq), 0);
        for (int i = 0; i < 3; i++) feed(3, "hypoOut");
        check("hypoOut.stateConst", int'(bus.state), 0);

        // Clamp of out-of-range indices.
        for (int i = 0; i < 4; i++) feed(15, "clamp");
        check("clamp.avgConst", int'(bus.avgIndex), 8);

        // Randomized traffic with sparse valid and random acks.
        repeat (400) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1, "rand");
        end
        // Enough back-to-back samples to saturate the counter.
        repeat (260) feed(int'($urandom_range(0, 15)), "sat");
        check("sat.countConst", int'(bus.sampleCount), 255);

        // Asynchronous reset while a request is pending.
        syncReset();
        for (int i = 0; i < 3; i++) feed(8, "preRst");
        check("preRst.reqConst", int'(bus.insulinReq), 1);
        bus.sampleValid = 1'b0;
        #1 rst = 1'b1;
        modelReset();
        #1;
        checkAll("asyncRst");
        check("asyncRst.reqConst", int'(bus.insulinReq), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        checkAll("postRst");

        // Resume operation after reset.
        repeat (40) begin
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                 $urandom_range(0, 2) == 0, "resume");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
